// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned IMEM_DEPTH = 1024;

  // MIPS sll $0,$0,0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: reset > squash > hold > capture.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        squash,
  input  logic        hold,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  // Register update with fixed priority; a squash still records the fetch PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_inst     <= NOP_INST;
      id_pc       <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (squash) begin
      id_inst     <= NOP_INST;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b0;
    end else if (!hold) begin
      id_inst     <= inst;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID register.
// Optional misaligned-redirect fault halt: define IF_ALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_halted
);

  import if_stage_pkg::*;

  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  logic         squash;
  logic         hold;
  fetch_state_t state;
  fetch_state_t state_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    state_next = state;
    pc_next    = pc_plus4;
    squash     = flush;
    hold       = stall;
    if (state == HALT) begin
      pc_next = pc;
      squash  = 1'b1;
    end else if (redirect) begin
      squash  = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_next = HALT;
        pc_next    = pc;
      end else begin
        pc_next = redirect_target;
      end
`else
      pc_next = redirect_target & ~32'd3;
`endif
    end else if (stall) begin
      pc_next = pc;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  assign fetch_halted = (state == HALT);
`else
  assign fetch_halted = 1'b0;
`endif

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .squash     (squash),
    .hold       (hold),
    .inst       (imem_inst),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_valid   (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_halted;

  logic [31:0] mem [1024];

  int passed = 0;
  int total  = 0;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // Expected architectural state.
  logic [31:0] m_pc, m_inst, m_idpc, m_idp4;
  logic        m_valid, m_halt;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid),
    .fetch_halted   (fetch_halted)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory, zero outside 1024 words.
  always_comb begin
    if (imem_addr[31:12] != 20'h0) imem_inst = 32'h0;
    else imem_inst = mem[imem_addr[11:2]];
  end

  function automatic logic [31:0] fetch(input logic [31:0] addr);
    if (addr >= 32'd4096) return 32'h0;
    return mem[addr[11:2]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, compare all outputs.
  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] tgt);
    logic bad;
    @(negedge clk);
    reset = r; stall = s; flush = f; redirect = rd; redirect_target = tgt;
    if (r) begin
      m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_idp4 = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_inst = 32'h0; m_valid = 1'b0; m_idpc = m_pc; m_idp4 = m_pc + 32'd4;
    end else begin
      bad = ALIGN_EN && rd && (tgt % 4 != 0);
      if (rd || f) begin
        m_inst = 32'h0; m_valid = 1'b0; m_idpc = m_pc; m_idp4 = m_pc + 32'd4;
      end else if (!s) begin
        m_inst = fetch(m_pc); m_valid = 1'b1; m_idpc = m_pc; m_idp4 = m_pc + 32'd4;
      end
      if (bad) m_halt = 1'b1;
      else if (rd) m_pc = tgt - (tgt % 4);
      else if (!s) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("id_inst", id_inst, m_inst);
    check("id_pc", id_pc, m_idpc);
    check("id_pc_plus4", id_pc_plus4, m_idp4);
    check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    check("fetch_halted", {31'h0, fetch_halted}, {31'h0, m_halt});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_idp4 = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0;

    // Reset and straight-line fetch
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_pc", imem_addr, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("edge1_inst", id_inst, 32'h11);
    step(0, 0, 0, 0, 32'h0);
    check("edge2_inst", id_inst, 32'h22);
    check("edge2_pc", imem_addr, 32'h8);

    // Two-cycle stall at pc=8
    step(0, 1, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    check("stall_pc", imem_addr, 32'h8);
    check("stall_inst", id_inst, 32'h22);
    step(0, 0, 0, 0, 32'h0);
    check("release_pc", imem_addr, 32'hC);
    check("release_inst", id_inst, 32'h33);
    step(0, 0, 0, 0, 32'h0);

    // Redirect from 0x10 to 0x40
    step(0, 0, 0, 1, 32'h40);
    check("redir_pc", imem_addr, 32'h40);
    check("redir_valid", {31'h0, id_valid}, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("redir_inst", id_inst, mem[16]);
    check("redir_idpc", id_pc, 32'h40);

    // Redirect beats stall; stall+flush squashes; reset during stall
    step(0, 1, 0, 1, 32'h80);
    check("rs_pc", imem_addr, 32'h80);
    step(0, 1, 1, 0, 32'h0);
    check("sf_pc", imem_addr, 32'h80);
    check("sf_valid", {31'h0, id_valid}, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 32'h200);
    check("rst_stall_pc", imem_addr, 32'h0);
    check("rst_stall_valid", {31'h0, id_valid}, 32'h0);

    // Wrap at top of address space, out-of-range fetch is a valid zero word
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'h0);
    check("wrap_pc", imem_addr, 32'h0);
    check("oor_inst", id_inst, 32'h0);
    check("oor_valid", {31'h0, id_valid}, 32'h1);
    step(0, 0, 0, 0, 32'h0);

    // Misaligned redirect
    step(0, 0, 0, 1, 32'h42);
    if (ALIGN_EN) check("mis_pc", imem_addr, 32'h4);
    else check("mis_pc", imem_addr, 32'h40);
    check("mis_halt", {31'h0, fetch_halted}, {31'h0, ALIGN_EN});
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    check("mis_clear", {31'h0, fetch_halted}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
      if ($urandom_range(0, 3) != 0) tgt = tgt & ~32'd3;
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), tgt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
